instr_read_sequencer: RTL
=========================

INSTR_READ_SEQUENCER -- requirements
Module: instr_read_sequencer

Interface
REQ-001 SHALL expose clk, input, 1, single clock; all state on its rising edge.
REQ-002 SHALL expose reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL expose start, input, 1, one-cycle request to begin a read sweep.
REQ-004 SHALL expose first_addr, input, address_t (5), first register location read.
REQ-005 SHALL expose count, input, 6, number of locations to read (0..63; values >32 clamped to 32).
REQ-006 SHALL expose direction, input, 1; 0 = increasing addresses, 1 = decreasing.
REQ-007 SHALL expose read_pointer, output, address_t (5), drives the instruction register read address.
REQ-008 SHALL expose instruction_word, input, instruction_t, combinational read data for read_pointer.
REQ-009 SHALL expose out_valid, output, 1, and out_ready, input, 1, as the downstream handshake.
REQ-010 SHALL expose out_word, output, instruction_t, and out_addr, output, 5, as the captured entry and its location.
REQ-011 SHALL expose busy, output, 1 (sweep in progress), and done, output, 1 (one-cycle end-of-sweep pulse).
REQ-012 SHALL expose err_count, output, 8, saturating count of result mismatches.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN.
REQ-014 IDLE with start=1 and count!=0: next cycle read_pointer=first_addr, remaining=min(count,32), busy=1, state RUN.
REQ-015 IDLE with start=1 and count=0: done=1 for exactly the next cycle, no output, state stays IDLE.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 In RUN, load condition = (out_valid=0 or out_ready=1) and remaining>0.
REQ-018 On load: out_word<=instruction_word, out_addr<=read_pointer, out_valid<=1, remaining decrements, read_pointer steps by +1 or -1 per direction.
REQ-019 read_pointer SHALL wrap modulo 32 (31->0 increasing, 0->31 decreasing).
REQ-020 Throughput SHALL be one entry per cycle while out_ready=1; latency start->first out_valid = 2 cycles.
REQ-021 out_valid=1 with out_ready=0: out_word, out_addr, read_pointer SHALL hold stable.
REQ-022 out_valid SHALL clear on acceptance when no new load occurs in the same cycle.
REQ-023 When remaining reaches 0, state SHALL go to DRAIN; in DRAIN, acceptance of the last word SHALL pulse done for one cycle, clear busy, return to IDLE.
REQ-024 Exactly min(count,32) words SHALL be emitted per sweep, in address order, no duplicates or drops.

Reset
REQ-025 reset SHALL asynchronously force state IDLE, read_pointer=0, out_valid=0, out_word=0, out_addr=0, busy=0, done=0, remaining=0, err_count=0.
REQ-026 reset mid-sweep SHALL abandon the sweep without a done pulse; after release the block SHALL accept a new start.

Configuration
REQ-027 Macro INSTR_READ_SEQ_RESULT_CHECK_EN SHALL enable the result checker.
REQ-028 With macro: on each accepted word, expected result = ZERO 0, PASSA op_a, PASSB op_b, ADD a+b, SUB a-b, MULT a*b, DIV a/b, MOD a%b, all signed and sign-extended to 64 bits; DIV/MOD with op_b=0 yield 0; a mismatch against out_word.result increments err_count, saturating at 255.
REQ-029 Without macro: err_count SHALL be tied to 0 and no checker logic SHALL exist.

Verification
REQ-030 start, first_addr=0, count=20, direction=0, out_ready=1 -> out_addr 0..19 on consecutive cycles, done one cycle after the last acceptance, busy low afterwards.
REQ-031 first_addr=2, count=5, direction=1 -> out_addr 2,1,0,31,30; first_addr=30, count=4, direction=0 -> 30,31,0,1.
REQ-032 count=8 with out_ready toggling 1,0,0,1,... -> out_word held stable while stalled, exactly 8 words, no duplicates.
REQ-033 count=0 -> done pulse next cycle, out_valid stays 0; count=40 -> exactly 32 words; start while busy -> ignored.
REQ-034 reset asserted after the 3rd word of a count=10 sweep -> all outputs zero immediately, no done; a new count=2 sweep then completes normally.
REQ-035 With macro: entries ADD 7+(-3), DIV 9/0, MULT -4*5 with a corrupted result on MULT -> err_count=1; without macro -> err_count=0.

Source files
------------

// File: rtl/instr_read_sequencer.sv
// Sweeps instruction register locations and streams each entry out over a valid/ready handshake.
// Define INSTR_READ_SEQ_RESULT_CHECK_EN to build the result checker that drives err_count.
package instr_read_seq_pkg;
    typedef logic [4:0] address_t;

    typedef enum logic [2:0] {
        OP_ZERO, OP_PASSA, OP_PASSB, OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_MOD
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [63:0] result;
    } instruction_t;
endpackage

// state | meaning
// IDLE  | waiting for start
// RUN   | loading entries while words remain
// DRAIN | last word loaded, waiting for its acceptance
module instr_read_sequencer
    import instr_read_seq_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  address_t     first_addr,
    input  logic [5:0]   count,
    input  logic         direction,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         out_valid,
    input  logic         out_ready,
    output instruction_t out_word,
    output logic [4:0]   out_addr,
    output logic         busy,
    output logic         done,
    output logic [7:0]   err_count
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t     state, state_nxt;
    logic [5:0] remaining;
    logic       dir_q;
    logic       accept, load, sweep_start, sweep_empty, sweep_end;

    assign accept = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        sweep_start = 1'b0;
        sweep_empty = 1'b0;
        sweep_end   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (count != 6'd0) begin
                        sweep_start = 1'b1;
                        state_nxt   = S_RUN;
                    end else begin
                        sweep_empty = 1'b1;
                    end
                end
            end
            S_RUN: begin
                load = (!out_valid || out_ready) && (remaining != 6'd0);
                if (load && remaining == 6'd1) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (accept) begin
                    sweep_end = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Direction is latched at start so a sweep cannot change course midway.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_pointer <= '0;
            remaining    <= '0;
            dir_q        <= 1'b0;
            out_valid    <= 1'b0;
            out_word     <= '0;
            out_addr     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= sweep_empty || sweep_end;
            if (sweep_start) begin
                read_pointer <= first_addr;
                remaining    <= (count > 6'd32) ? 6'd32 : count;
                dir_q        <= direction;
                busy         <= 1'b1;
            end
            if (sweep_end) busy <= 1'b0;
            if (load) begin
                out_word     <= instruction_word;
                out_addr     <= read_pointer;
                out_valid    <= 1'b1;
                remaining    <= remaining - 6'd1;
                read_pointer <= dir_q ? read_pointer - 5'd1 : read_pointer + 5'd1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef INSTR_READ_SEQ_RESULT_CHECK_EN
    logic signed [63:0] op_a_ext, op_b_ext, expected;

    always_comb begin
        op_a_ext = {{32{out_word.op_a[31]}}, out_word.op_a};
        op_b_ext = {{32{out_word.op_b[31]}}, out_word.op_b};
        expected = '0;
        case (out_word.opcode)
            OP_ZERO:  expected = '0;
            OP_PASSA: expected = op_a_ext;
            OP_PASSB: expected = op_b_ext;
            OP_ADD:   expected = op_a_ext + op_b_ext;
            OP_SUB:   expected = op_a_ext - op_b_ext;
            OP_MULT:  expected = op_a_ext * op_b_ext;
            OP_DIV:   expected = (op_b_ext == 64'sd0) ? 64'sd0 : op_a_ext / op_b_ext;
            OP_MOD:   expected = (op_b_ext == 64'sd0) ? 64'sd0 : op_a_ext % op_b_ext;
            default:  expected = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (accept && (expected != out_word.result) && (err_count != 8'hff)) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    assign err_count = '0;
`endif

endmodule
